// File: rtl/audio_pkg.sv
// Shared types and helpers for the audio record/playback engine.
package audio_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RECORD = 2'd1,
    ST_PLAY   = 2'd2
  } state_t;

  localparam int DEF_DATA_W   = 16;
  localparam int DEF_CHANNELS = 2;
  localparam int DEF_DEPTH    = 4096;
  localparam int DEF_ADDR_W   = $clog2(DEF_DEPTH);
  localparam int DEF_FRAME_W  = DEF_CHANNELS * DEF_DATA_W;

  // |x| for a w-bit two's complement value carried in 32 bits; the most
  // negative code has no positive twin, so it clips to the largest positive.
  function automatic logic [31:0] sat_abs(input logic signed [31:0] x, input int w);
    logic signed [31:0] lim;
    lim = (32'sd1 <<< (w - 1)) - 32'sd1;
    if (x < -lim)
      return lim;
    else if (x < 0)
      return -x;
    return x;
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// Synchronises a raw button level, accepts it once stable for DEBOUNCE_CYC
// cycles, and emits a one-cycle pulse on each accepted rising edge.
module btn_debounce #(
  parameter int DEBOUNCE_CYC = 50000
) (
  input  logic clk,
  input  logic reset,
  input  logic raw,
  output logic pulse
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYC + 1);

  logic [1:0]       sync_q;
  logic             level;
  logic [CNT_W-1:0] cnt;

  // The counter only runs while the synchronised input disagrees with the
  // accepted level, so any bounce shorter than the window restarts it.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q <= '0;
      level  <= 1'b0;
      cnt    <= '0;
      pulse  <= 1'b0;
    end else begin
      sync_q <= {sync_q[0], raw};
      pulse  <= 1'b0;
      if (sync_q[1] == level) begin
        cnt <= '0;
      end else if (cnt == CNT_W'(DEBOUNCE_CYC - 1)) begin
        level <= sync_q[1];
        cnt   <= '0;
        pulse <= sync_q[1];
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/audio_sample_engine.sv
// Multi-channel record/playback engine with live passthrough and a
// peak-hold thermometer level meter.
module audio_sample_engine
  import audio_pkg::*;
#(
  parameter int DATA_W       = 16,
  parameter int CHANNELS     = 2,
  parameter int DEPTH        = 4096,
  parameter int LED_W        = 10,
  parameter int DEBOUNCE_CYC = 50000,
  parameter int DECAY_FRAMES = 1024
) (
  input  logic                       clk_clk,
  input  logic                       reset_reset,
  input  logic                       sync_in,
  input  logic [CHANNELS*DATA_W-1:0] data_in,
  input  logic                       record_btn_in,
  input  logic                       play_btn_in,
  input  logic                       loop_en,
  input  logic                       passthru_en,
  output logic [CHANNELS*DATA_W-1:0] data_out,
  output logic                       data_out_valid,
  output logic [LED_W-1:0]           led_out,
  output logic [1:0]                 state_out,
  output logic                       full
);

  localparam int ADDR_W  = $clog2(DEPTH);
  localparam int PTR_W   = ADDR_W + 1;
  localparam int FRAME_W = CHANNELS * DATA_W;
  localparam int DC_W    = $clog2(DECAY_FRAMES);
  localparam int STEP    = ((2 ** (DATA_W - 1)) - 1) / LED_W;

  logic rec_ev, play_ev;

  btn_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_rec_btn (
    .clk(clk_clk), .reset(reset_reset), .raw(record_btn_in), .pulse(rec_ev)
  );

  btn_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_play_btn (
    .clk(clk_clk), .reset(reset_reset), .raw(play_btn_in), .pulse(play_ev)
  );

  state_t             state, state_nxt;
  logic [PTR_W-1:0]   wr_ptr, rd_ptr, rec_len, len_val;
  logic               wr_en, wr_clr, rd_en, rd_clr, rd_wrap, len_ld, full_set, full_clr;
  logic [FRAME_W-1:0] mem [DEPTH];
  logic [FRAME_W-1:0] rd_data, out_reg;
  logic               pend_ram, pend_pass, pass_now, tick;
  logic [DC_W-1:0]    dcnt;
  logic [31:0]        peak, peak_base, peak_nxt, mag;

  always_ff @(posedge clk_clk) begin
    if (reset_reset) state <= ST_IDLE;
    else             state <= state_nxt;
  end

  // Pointer and length updates are decoded here as strobes so that the
  // priority between sync_in, rec_ev and play_ev lives in one place.
  always_comb begin
    state_nxt = state;
    wr_en     = 1'b0;
    wr_clr    = 1'b0;
    rd_en     = 1'b0;
    rd_clr    = 1'b0;
    rd_wrap   = 1'b0;
    len_ld    = 1'b0;
    len_val   = '0;
    full_set  = 1'b0;
    full_clr  = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (rec_ev) begin
          state_nxt = ST_RECORD;
          wr_clr    = 1'b1;
          full_clr  = 1'b1;
        end else if (play_ev && rec_len != '0) begin
          state_nxt = ST_PLAY;
          rd_clr    = 1'b1;
        end
      end
      ST_RECORD: begin
        wr_en = sync_in;
        if (sync_in && wr_ptr == PTR_W'(DEPTH - 1)) begin
          full_set  = 1'b1;
          len_ld    = 1'b1;
          len_val   = PTR_W'(DEPTH);
          state_nxt = ST_IDLE;
        end else if (rec_ev) begin
          len_ld    = 1'b1;
          len_val   = sync_in ? wr_ptr + 1'b1 : wr_ptr;
          state_nxt = ST_IDLE;
        end
      end
      ST_PLAY: begin
        if (sync_in) begin
          rd_en = 1'b1;
          if (rd_ptr == rec_len - 1'b1) begin
            rd_wrap = 1'b1;
            if (!loop_en) state_nxt = ST_IDLE;
          end
        end
        if (rec_ev) begin
          state_nxt = ST_RECORD;
          wr_clr    = 1'b1;
          full_clr  = 1'b1;
        end else if (play_ev) begin
          state_nxt = ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Kept free of reset so the buffer maps onto block RAM.
  always_ff @(posedge clk_clk) begin
    if (wr_en) mem[wr_ptr[ADDR_W-1:0]] <= data_in;
    if (rd_en) rd_data <= mem[rd_ptr[ADDR_W-1:0]];
  end

  assign pass_now = sync_in && (state != ST_PLAY) && passthru_en;
  assign tick     = sync_in && (dcnt == DC_W'(DECAY_FRAMES - 1));

  always_comb begin
    mag       = sat_abs(32'(signed'(data_out[DATA_W-1:0])), DATA_W);
    peak_base = tick ? (peak >> 1) : peak;
    peak_nxt  = peak_base;
    if (data_out_valid && mag > peak_base) peak_nxt = mag;
  end

  always_ff @(posedge clk_clk) begin
    if (reset_reset) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      rec_len   <= '0;
      full      <= 1'b0;
      pend_ram  <= 1'b0;
      pend_pass <= 1'b0;
      out_reg   <= '0;
      dcnt      <= '0;
      peak      <= '0;
    end else begin
      if (wr_clr)     wr_ptr <= '0;
      else if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (rd_clr)     rd_ptr <= '0;
      else if (rd_en) rd_ptr <= rd_wrap ? '0 : rd_ptr + 1'b1;
      if (len_ld)     rec_len <= len_val;
      if (full_set)      full <= 1'b1;
      else if (full_clr) full <= 1'b0;
      pend_ram  <= rd_en;
      pend_pass <= pass_now;
      // out_reg captures whatever was last emitted so data_out holds between pulses.
      if (pass_now)      out_reg <= data_in;
      else if (pend_ram) out_reg <= rd_data;
      if (sync_in) dcnt <= tick ? '0 : dcnt + 1'b1;
      peak <= peak_nxt;
    end
  end

  assign data_out       = pend_ram ? rd_data : out_reg;
  assign data_out_valid = pend_ram | pend_pass;
  assign state_out      = state;

  always_comb begin
    led_out = '0;
    for (int i = 0; i < LED_W; i++)
      led_out[i] = (peak >= 32'((i + 1) * STEP));
  end

endmodule

// File: tb/tb_audio_sample_engine.sv
// Directed scoreboard bench for audio_sample_engine with a small debounce
// window and an 8-frame buffer.
module tb_audio_sample_engine;

  logic        clk = 1'b0;
  logic        reset_reset;
  logic        sync_in;
  logic [31:0] data_in;
  logic        record_btn_in;
  logic        play_btn_in;
  logic        loop_en;
  logic        passthru_en;
  logic [31:0] data_out;
  logic        data_out_valid;
  logic [9:0]  led_out;
  logic [1:0]  state_out;
  logic        full;

  int          total = 0;
  int          bad   = 0;
  logic [31:0] exp_q[$];
  logic [31:0] model_peak;
  int          model_sync;

  always #5 clk = ~clk;

  audio_sample_engine #(
    .DATA_W(16), .CHANNELS(2), .DEPTH(8), .LED_W(10),
    .DEBOUNCE_CYC(4), .DECAY_FRAMES(1024)
  ) dut (
    .clk_clk(clk), .reset_reset(reset_reset), .sync_in(sync_in), .data_in(data_in),
    .record_btn_in(record_btn_in), .play_btn_in(play_btn_in), .loop_en(loop_en),
    .passthru_en(passthru_en), .data_out(data_out), .data_out_valid(data_out_valid),
    .led_out(led_out), .state_out(state_out), .full(full)
  );

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Every emitted frame is matched against the oldest outstanding expectation.
  always @(negedge clk) begin
    if (data_out_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $error("[TB] FAIL stray_pulse observed=%h expected=no_pulse", data_out);
      end else begin
        check_output("frame_data", data_out, exp_q.pop_front());
      end
    end
  end

  task automatic apply_stimulus(input logic [31:0] frame, input bit expect_pulse,
                                input logic [31:0] exp_frame);
    @(negedge clk);
    sync_in = 1'b1;
    data_in = frame;
    if (expect_pulse) exp_q.push_back(exp_frame);
    @(negedge clk);
    sync_in = 1'b0;
    check_output("pulse_latency", {31'b0, data_out_valid}, {31'b0, expect_pulse});
  endtask

  task automatic press_buttons(input bit rec, input bit play);
    @(negedge clk);
    record_btn_in = rec;
    play_btn_in   = play;
    repeat (12) @(negedge clk);
    record_btn_in = 1'b0;
    play_btn_in   = 1'b0;
    repeat (12) @(negedge clk);
  endtask

  function automatic logic [31:0] model_mag(input logic [15:0] ch0);
    if (ch0 == 16'h8000) return 32'd32767;
    if (ch0[15])         return 32'(16'(~ch0 + 16'd1));
    return {16'd0, ch0};
  endfunction

  function automatic logic [31:0] led_of(input logic [31:0] p);
    logic [31:0] v;
    v = '0;
    for (int i = 0; i < 10; i++) v[i] = (p >= 32'((i + 1) * 3276));
    return v;
  endfunction

  task automatic meter_frame(input logic [31:0] frame);
    model_sync++;
    if (model_sync % 1024 == 0) model_peak = model_peak >> 1;
    if (model_mag(frame[15:0]) > model_peak) model_peak = model_mag(frame[15:0]);
    apply_stimulus(frame, 1'b1, frame);
  endtask

  initial begin
    reset_reset = 1'b1; sync_in = 1'b0; data_in = '0;
    record_btn_in = 1'b0; play_btn_in = 1'b0; loop_en = 1'b0; passthru_en = 1'b0;
    repeat (3) @(negedge clk);
    reset_reset = 1'b0;
    @(negedge clk);
    check_output("reset_state", {30'b0, state_out}, 32'd0);
    check_output("reset_data", data_out, 32'd0);
    check_output("reset_valid", {31'b0, data_out_valid}, 32'd0);
    check_output("reset_led", {22'b0, led_out}, 32'd0);
    check_output("reset_full", {31'b0, full}, 32'd0);

    $display("[TB] play with empty take and a short glitch");
    press_buttons(1'b0, 1'b1);
    check_output("play_empty", {30'b0, state_out}, 32'd0);
    @(negedge clk); record_btn_in = 1'b1;
    repeat (2) @(negedge clk); record_btn_in = 1'b0;
    repeat (12) @(negedge clk);
    check_output("glitch", {30'b0, state_out}, 32'd0);

    $display("[TB] record three frames and play back");
    press_buttons(1'b1, 1'b0);
    check_output("rec_start", {30'b0, state_out}, 32'd1);
    for (int k = 1; k <= 3; k++) apply_stimulus(32'h0001_0001 * k, 1'b0, '0);
    press_buttons(1'b1, 1'b0);
    check_output("rec_stop", {30'b0, state_out}, 32'd0);
    check_output("rec_not_full", {31'b0, full}, 32'd0);
    press_buttons(1'b0, 1'b1);
    check_output("play_start", {30'b0, state_out}, 32'd2);
    for (int k = 1; k <= 3; k++) apply_stimulus(32'hDEAD_0000, 1'b1, 32'h0001_0001 * k);
    check_output("play_end", {30'b0, state_out}, 32'd0);
    apply_stimulus(32'h1234_5678, 1'b0, '0);

    $display("[TB] looped playback");
    loop_en = 1'b1;
    press_buttons(1'b0, 1'b1);
    for (int k = 0; k < 7; k++) apply_stimulus(32'h0, 1'b1, 32'h0001_0001 * ((k % 3) + 1));
    check_output("loop_running", {30'b0, state_out}, 32'd2);
    press_buttons(1'b0, 1'b1);
    check_output("loop_stop", {30'b0, state_out}, 32'd0);
    apply_stimulus(32'h0, 1'b0, '0);
    apply_stimulus(32'h0, 1'b0, '0);
    loop_en = 1'b0;

    $display("[TB] fill the buffer");
    press_buttons(1'b1, 1'b0);
    for (int k = 1; k <= 10; k++) begin
      apply_stimulus(32'h0010_0010 + 32'h0001_0001 * k, 1'b0, '0);
      if (k == 7) begin
        check_output("full_before", {31'b0, full}, 32'd0);
        check_output("rec_before_full", {30'b0, state_out}, 32'd1);
      end
      if (k == 8) begin
        check_output("full_set", {31'b0, full}, 32'd1);
        check_output("idle_after_full", {30'b0, state_out}, 32'd0);
      end
    end
    press_buttons(1'b0, 1'b1);
    for (int k = 1; k <= 8; k++) apply_stimulus(32'h0, 1'b1, 32'h0010_0010 + 32'h0001_0001 * k);
    check_output("full_play_end", {30'b0, state_out}, 32'd0);

    $display("[TB] simultaneous buttons");
    press_buttons(1'b1, 1'b1);
    check_output("rec_wins", {30'b0, state_out}, 32'd1);
    check_output("full_cleared", {31'b0, full}, 32'd0);
    press_buttons(1'b1, 1'b0);
    press_buttons(1'b0, 1'b1);
    check_output("play_zero_len", {30'b0, state_out}, 32'd0);

    $display("[TB] reset during playback");
    press_buttons(1'b1, 1'b0);
    apply_stimulus(32'h00AA_00AA, 1'b0, '0);
    apply_stimulus(32'h00BB_00BB, 1'b0, '0);
    press_buttons(1'b1, 1'b0);
    press_buttons(1'b0, 1'b1);
    check_output("play_before_reset", {30'b0, state_out}, 32'd2);
    @(negedge clk);
    sync_in = 1'b1; reset_reset = 1'b1;
    @(negedge clk);
    sync_in = 1'b0;
    check_output("abort_state", {30'b0, state_out}, 32'd0);
    check_output("abort_data", data_out, 32'd0);
    check_output("abort_valid", {31'b0, data_out_valid}, 32'd0);
    check_output("abort_led", {22'b0, led_out}, 32'd0);
    reset_reset = 1'b0;

    $display("[TB] passthrough meter and decay");
    passthru_en = 1'b1;
    model_peak  = '0;
    model_sync  = 0;
    meter_frame(32'h0000_7FFF);
    @(negedge clk);
    check_output("led_max", {22'b0, led_out}, led_of(model_peak));
    meter_frame(32'h0000_8000);
    @(negedge clk);
    check_output("led_neg_full", {22'b0, led_out}, led_of(model_peak));
    while (model_sync < 4096) begin
      meter_frame(32'h5555_0000);
      if (model_sync == 1023 || model_sync % 1024 == 0) begin
        @(negedge clk);
        check_output($sformatf("led_decay_%0d", model_sync), {22'b0, led_out}, led_of(model_peak));
      end
    end
    check_output("led_zero", {22'b0, led_out}, 32'd0);
    repeat (2) @(negedge clk);
    check_output("queue_drained", 32'(exp_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
